apb_subsystem_top: RTL and testbench

Self-contained APB subsystem: a simple transfer-request front end drives an internal APB master FSM, which talks to an internal APB slave backed by a byte-wide register memory. The block converts single-cycle-sampled write/read requests into standard APB SETUP/ACCESS phases and returns read data with a valid strobe. It serves as the top-level wrapper for APB protocol bring-up and for connecting APB peripherals.

---
 rtl/apb_subsystem_top.sv | 149 ++++++++++++++
 tb/tb_apb_subsystem_top.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_subsystem_top.sv
// Request front end -> APB master FSM -> APB slave with byte-wide register memory.
// Reads return on trf_rdata with a one-cycle trf_rdata_valid strobe.
module apb_subsystem_top #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              trf_valid,
  input  logic [1:0]        trf_enc,
  input  logic [ADDR_W-1:0] trf_addr,
  input  logic [DATA_W-1:0] trf_wdata,
  output logic [DATA_W-1:0] trf_rdata,
  output logic              trf_rdata_valid
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              r_state, w_state_d;
  logic                r_psel, w_psel_d;
  logic                r_penable, w_penable_d;
  logic                r_pwrite, w_pwrite_d;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_d;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_d;
  logic                r_pready;
  logic [CntW-1:0]     r_wait_cnt;
  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rdata_valid;
  logic [DATA_W-1:0]   w_prdata;
  logic                w_req;
  logic                w_done;

  assign w_req  = trf_valid && (trf_enc == 2'b01 || trf_enc == 2'b10);
  assign w_done = r_psel && r_penable && r_pready;

  // Master FSM: state and APB request registers
  always_ff @(posedge pclk or posedge prstn) begin
    if (prstn) begin
      r_state   <= StIdle;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_psel    <= w_psel_d;
      r_penable <= w_penable_d;
      r_pwrite  <= w_pwrite_d;
      r_paddr   <= w_paddr_d;
      r_pwdata  <= w_pwdata_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_psel_d    = r_psel;
    w_penable_d = r_penable;
    w_pwrite_d  = r_pwrite;
    w_paddr_d   = r_paddr;
    w_pwdata_d  = r_pwdata;
    unique case (r_state)
      StIdle: begin
        w_psel_d = 1'b0;
        if (w_req) begin
          w_state_d   = StSetup;
          w_psel_d    = 1'b1;
          w_penable_d = 1'b0;
          w_pwrite_d  = (trf_enc == 2'b01);
          w_paddr_d   = trf_addr;
          w_pwdata_d  = trf_wdata;
        end
      end
      StSetup: begin
        w_state_d   = StAccess;
        w_penable_d = 1'b1;
      end
      StAccess: begin
        if (r_pready) begin
          // Completing edge doubles as the sampling point for a back-to-back request
          if (w_req) begin
            w_state_d   = StSetup;
            w_penable_d = 1'b0;
            w_pwrite_d  = (trf_enc == 2'b01);
            w_paddr_d   = trf_addr;
            w_pwdata_d  = trf_wdata;
          end else begin
            w_state_d   = StIdle;
            w_psel_d    = 1'b0;
            w_penable_d = 1'b0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Slave wait-state counter; PREADY is armed while SETUP is on the bus
  always_ff @(posedge pclk or posedge prstn) begin
    if (prstn) begin
      r_pready   <= 1'b0;
      r_wait_cnt <= '0;
    end else if (r_psel && !r_penable) begin
      r_pready   <= (WAIT_CYCLES == 0);
      r_wait_cnt <= '0;
    end else if (r_psel && r_penable) begin
      if (r_pready) begin
        r_pready <= 1'b0;
      end else begin
        r_wait_cnt <= r_wait_cnt + CntW'(1);
        r_pready   <= ((r_wait_cnt + CntW'(1)) == WaitLast);
      end
    end
  end

  assign w_prdata = (r_psel && r_penable) ? r_mem[r_paddr] : '0;

  always_ff @(posedge pclk or posedge prstn) begin
    if (prstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_done && r_pwrite) begin
      r_mem[r_paddr] <= r_pwdata;
    end
  end

  always_ff @(posedge pclk or posedge prstn) begin
    if (prstn) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_done && !r_pwrite;
      if (w_done && !r_pwrite) begin
        r_rdata <= w_prdata;
      end
    end
  end

  assign trf_rdata       = r_rdata;
  assign trf_rdata_valid = r_rdata_valid;

endmodule

// File: tb/tb_apb_subsystem_top.sv
// Scoreboard bench: one DUT with no wait states, one with two, checked against a memory model.
module tb_apb_subsystem_top;

  logic       pclk = 1'b0;
  logic       prstn;
  logic       v0, v2;
  logic [1:0] e0, e2;
  logic [7:0] a0, a2, w0, w2;
  logic [7:0] rdata0, rdata2;
  logic       rvalid0, rvalid2;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q0[$];
  exp_t       q2[$];
  logic [7:0] m0 [256];
  logic [7:0] m2 [256];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] b_enc [32];
  logic [7:0] b_addr [32];
  logic [7:0] b_data [32];

  apb_subsystem_top #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .pclk            (pclk),
    .prstn           (prstn),
    .trf_valid       (v0),
    .trf_enc         (e0),
    .trf_addr        (a0),
    .trf_wdata       (w0),
    .trf_rdata       (rdata0),
    .trf_rdata_valid (rvalid0)
  );

  apb_subsystem_top #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .pclk            (pclk),
    .prstn           (prstn),
    .trf_valid       (v2),
    .trf_enc         (e2),
    .trf_addr        (a2),
    .trf_wdata       (w2),
    .trf_rdata       (rdata2),
    .trf_rdata_valid (rvalid2)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m0[i] = 8'h00;
      m2[i] = 8'h00;
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [1:0] e,
                       input logic [7:0] a, input logic [7:0] d);
    if (which == 0) begin
      v0 = v; e0 = e; a0 = a; w0 = d;
    end else begin
      v2 = v; e2 = e; a2 = a; w2 = d;
    end
  endtask

  // Present a request so it is sampled at the next rising edge; record the model effect
  task automatic issue(input int which, input logic [1:0] enc, input logic [7:0] a,
                       input logic [7:0] d, output int es);
    exp_t x;
    int   lat;
    lat = (which == 0) ? 2 : 4;
    drive(which, 1'b1, enc, a, d);
    @(posedge pclk);
    #1;
    es = cyc;
    if (enc == 2'b01) begin
      if (which == 0) m0[a] = d;
      else m2[a] = d;
    end else if (enc == 2'b10) begin
      x.data = (which == 0) ? m0[a] : m2[a];
      x.due  = es + lat;
      if (which == 0) q0.push_back(x);
      else q2.push_back(x);
    end
  endtask

  // Isolated transfer with scrambled inputs while in flight; returns with the FSM idle
  task automatic single(input int which, input logic [1:0] enc, input logic [7:0] a,
                        input logic [7:0] d);
    int es;
    int lat;
    logic real_req;
    lat = (which == 0) ? 2 : 4;
    real_req = (enc == 2'b01 || enc == 2'b10);
    issue(which, enc, a, d, es);
    @(negedge pclk);
    drive(which, real_req, 2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
    @(negedge pclk);
    drive(which, 1'b0, 2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
    repeat (lat - 1) @(negedge pclk);
  endtask

  // Back-to-back sequence on the zero-wait DUT from the b_* tables
  task automatic b2b(input int n);
    int es;
    for (int i = 0; i < n; i++) begin
      issue(0, b_enc[i], b_addr[i], b_data[i], es);
      @(negedge pclk);
      if (i < n - 1) drive(0, 1'b1, b_enc[i + 1], b_addr[i + 1], b_data[i + 1]);
      else drive(0, 1'b0, 2'b00, 8'($urandom), 8'($urandom));
      @(negedge pclk);
    end
    @(negedge pclk);
  endtask

  task automatic mon_one(input int which, input logic vld, input logic [7:0] dat);
    exp_t x;
    if (!vld) return;
    if ((which == 0 && q0.size() == 0) || (which != 0 && q2.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_valid dut%0d actual=valid data=0x%0h expected=no strobe",
               which * 2, dat);
      return;
    end
    if (which == 0) x = q0.pop_front();
    else x = q2.pop_front();
    check($sformatf("rdata_dut%0d", which * 2), int'(dat), int'(x.data));
    check($sformatf("latency_dut%0d", which * 2), cyc, x.due);
  endtask

  initial begin
    forever begin
      @(posedge pclk);
      #1;
      mon_one(0, rvalid0, rdata0);
      mon_one(1, rvalid2, rdata2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int es;
    prstn = 1'b1;
    drive(0, 1'b0, 2'b00, 8'h00, 8'h00);
    drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
    model_reset();
    repeat (2) @(negedge pclk);
    check("reset_rdata0", int'(rdata0), 0);
    check("reset_rvalid0", int'(rvalid0), 0);
    check("reset_rdata2", int'(rdata2), 0);
    check("reset_rvalid2", int'(rvalid2), 0);
    prstn = 1'b0;
    @(negedge pclk);

    for (int i = 0; i < 3; i++) single(0, 2'b10, 8'($urandom), 8'h00);

    single(0, 2'b01, 8'h00, 8'h01);
    single(0, 2'b10, 8'h00, 8'h00);

    b_enc = '{default: 2'b01};
    b_addr[0] = 8'h00; b_data[0] = 8'h01;
    b_addr[1] = 8'h01; b_data[1] = 8'h02;
    b_addr[2] = 8'h02; b_data[2] = 8'h03;
    b_addr[3] = 8'h04; b_data[3] = 8'h04;
    b_addr[4] = 8'h05; b_data[4] = 8'h05;
    b2b(5);
    for (int i = 0; i < 6; i++) begin
      b_enc[i] = 2'b10; b_addr[i] = 8'(i); b_data[i] = 8'($urandom);
    end
    b2b(6);

    // write then read-after-write, back to back
    b_enc[0] = 2'b01; b_addr[0] = 8'h40; b_data[0] = 8'h9C;
    b_enc[1] = 2'b10; b_addr[1] = 8'h40; b_data[1] = 8'h00;
    b2b(2);

    single(0, 2'b01, 8'h30, 8'h77);
    single(0, 2'b10, 8'h30, 8'h00);
    single(0, 2'b10, 8'h31, 8'h00);

    single(0, 2'b00, 8'h00, 8'hEE);
    single(0, 2'b11, 8'h01, 8'hEE);
    single(0, 2'b10, 8'h00, 8'h00);
    single(0, 2'b10, 8'h01, 8'h00);

    for (int i = 0; i < 30; i++)
      single(0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      b_enc[i]  = 2'($urandom_range(1, 2));
      b_addr[i] = 8'($urandom_range(0, 15));
      b_data[i] = 8'($urandom);
    end
    b2b(20);

    single(1, 2'b01, 8'h20, 8'h5C);
    single(1, 2'b10, 8'h20, 8'h00);
    single(1, 2'b10, 8'h21, 8'h00);
    single(1, 2'b10, 8'h20, 8'h00);

    // Abort a wait-stated write in ACCESS with an asynchronous reset between edges
    issue(1, 2'b01, 8'h10, 8'hAA, es);
    @(negedge pclk);
    @(negedge pclk);
    drive(1, 1'b0, 2'b00, 8'h00, 8'h00);
    check("queue0_empty_before_reset", q0.size(), 0);
    check("queue2_empty_before_reset", q2.size(), 0);
    #2;
    prstn = 1'b1;
    #1;
    model_reset();
    check("async_rdata2", int'(rdata2), 0);
    check("async_rvalid2", int'(rvalid2), 0);
    check("async_rdata0", int'(rdata0), 0);
    @(posedge pclk);
    @(negedge pclk);
    prstn = 1'b0;
    @(negedge pclk);

    single(1, 2'b10, 8'h10, 8'h00);
    single(1, 2'b10, 8'h20, 8'h00);
    single(0, 2'b10, 8'h00, 8'h00);
    single(0, 2'b10, 8'h40, 8'h00);

    repeat (6) @(negedge pclk);
    check("queue0_drained", q0.size(), 0);
    check("queue2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
